// File: rtl/ram_delay_pkg.sv
// Shared definitions for the RAM delay-line controller.
//   state_t  : controller state encoding (one spare code, recovered to S_BOOT)
//   MIN_DL_N : smallest delay length the delay line can realise
package ram_delay_pkg;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_PRIME  = 3'd3,
    S_ACK    = 3'd4,
    S_HOLD   = 3'd5,
    S_IDLE   = 3'd6
  } state_t;

  localparam int MIN_DL_N = 2;

endpackage

// File: rtl/ram_delay_ctrl.sv
// Controller that (re)programs the length of an external RAM delay line.
// At boot it applies P_N_DEFAULT; afterwards it accepts level requests
// (cfg_req/cfg_ack handshake), drives the new length and a one-cycle reset
// to the delay line, then waits for the delay line's valid (optionally with
// a timeout) before acknowledging.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   cfg_req      level request, held until cfg_ack
//   cfg_n        requested delay length (sampled on acceptance)
//   cfg_timeout  max cycles to wait for dl_valid, 0 = unlimited (sampled on acceptance)
//   cfg_ack      one-cycle completion pulse
//   cfg_err      1 with cfg_ack when rejected (length < 2) or timed out
//   dl_n         delay length to the delay line
//   dl_rst       one-cycle reset pulse to the delay line
//   dl_valid     valid from the delay line
//   busy         controller not idle
//   ready        idle and delay line valid
//
// All status outputs are registered decodes of the current state, so each
// one trails the state register by one cycle (e.g. dl_rst is high during
// the cycle after S_APPLY).
module ram_delay_ctrl
  import ram_delay_pkg::*;
#(
  parameter int P_NBITS_ADDR = 8,
  parameter int P_NBITS_TO   = 16,
  parameter int P_N_DEFAULT  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_req,
  input  logic [P_NBITS_ADDR-1:0] cfg_n,
  input  logic [P_NBITS_TO-1:0]   cfg_timeout,
  output logic                    cfg_ack,
  output logic                    cfg_err,
  output logic [P_NBITS_ADDR-1:0] dl_n,
  output logic                    dl_rst,
  input  logic                    dl_valid,
  output logic                    busy,
  output logic                    ready
);

  localparam logic [P_NBITS_TO-1:0] TO_MAX = {P_NBITS_TO{1'b1}};

  state_t                  state, state_nxt;
  logic                    boot_q, boot_nxt;     // current sequence is the boot one
  logic                    err_q, err_nxt;       // outcome reported with the ack
  logic                    settle_q, settle_nxt; // second S_SETTLE cycle
  logic [P_NBITS_TO-1:0]   tmo_q, tmo_nxt;
  logic [P_NBITS_TO-1:0]   to_cnt, to_cnt_nxt;
  logic [P_NBITS_TO-1:0]   to_cnt_inc;
  logic [P_NBITS_ADDR-1:0] dl_n_nxt;

  // Saturating increment: the counter parks at its maximum instead of wrapping.
  assign to_cnt_inc = (to_cnt == TO_MAX) ? to_cnt : to_cnt + P_NBITS_TO'(1);

  always_comb begin
    state_nxt  = state;
    boot_nxt   = boot_q;
    err_nxt    = err_q;
    settle_nxt = settle_q;
    tmo_nxt    = tmo_q;
    to_cnt_nxt = to_cnt;
    dl_n_nxt   = dl_n;

    case (state)
      S_BOOT: begin
        dl_n_nxt  = P_NBITS_ADDR'(P_N_DEFAULT);
        boot_nxt  = 1'b1;
        err_nxt   = 1'b0;
        tmo_nxt   = '0;          // boot waits for valid without limit
        state_nxt = S_APPLY;
      end

      S_APPLY: begin
        settle_nxt = 1'b0;
        state_nxt  = S_SETTLE;
      end

      // dl_valid is deliberately ignored here: it still reflects the old
      // length until the delay line has registered the reset.
      S_SETTLE: begin
        if (settle_q) begin
          to_cnt_nxt = '0;
          state_nxt  = S_PRIME;
        end else begin
          settle_nxt = 1'b1;
        end
      end

      // to_cnt_inc equals the number of cycles spent in S_PRIME including
      // this one, so a timeout of T leaves after exactly T cycles.
      // dl_valid is checked first so it wins a same-cycle tie.
      S_PRIME: begin
        to_cnt_nxt = to_cnt_inc;
        if (dl_valid) begin
          err_nxt   = 1'b0;
          state_nxt = S_ACK;
        end else if ((tmo_q != '0) && (to_cnt_inc >= tmo_q)) begin
          err_nxt   = 1'b1;
          state_nxt = S_ACK;
        end
      end

      S_ACK: begin
        state_nxt = boot_q ? S_IDLE : S_HOLD;
      end

      // A held request must drop before another one can be accepted.
      S_HOLD: begin
        if (!cfg_req) state_nxt = S_IDLE;
      end

      S_IDLE: begin
        if (cfg_req) begin
          boot_nxt = 1'b0;
          tmo_nxt  = cfg_timeout;
          if (cfg_n < P_NBITS_ADDR'(MIN_DL_N)) begin
            err_nxt   = 1'b1;
            state_nxt = S_ACK;
          end else begin
            dl_n_nxt  = cfg_n;
            state_nxt = S_APPLY;
          end
        end
      end

      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      boot_q   <= 1'b1;
      err_q    <= 1'b0;
      settle_q <= 1'b0;
      to_cnt   <= '0;
      dl_n     <= P_NBITS_ADDR'(P_N_DEFAULT);
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
      dl_rst   <= 1'b0;
      busy     <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      boot_q   <= boot_nxt;
      err_q    <= err_nxt;
      settle_q <= settle_nxt;
      to_cnt   <= to_cnt_nxt;
      dl_n     <= dl_n_nxt;
      cfg_ack  <= (state == S_ACK) && !boot_q;
      cfg_err  <= (state == S_ACK) && !boot_q && err_q;
      dl_rst   <= (state == S_APPLY);
      busy     <= (state != S_IDLE);
      ready    <= (state == S_IDLE) && dl_valid;
    end
  end

  // The timeout value is only consumed in S_PRIME, which is always reached
  // after S_BOOT or S_IDLE has loaded it, so it needs no reset.
  always_ff @(posedge clk) begin
    tmo_q <= tmo_nxt;
  end

endmodule

// File: tb/tb_ram_delay_ctrl.sv
module tb_ram_delay_ctrl;

  localparam int MIN_N = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_req;
  logic [7:0]  cfg_n;
  logic [15:0] cfg_timeout;
  logic        cfg_ack;
  logic        cfg_err;
  logic [7:0]  dl_n;
  logic        dl_rst;
  logic        dl_valid;
  logic        busy;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_dl_n = 16;   // reference: length currently applied to the delay line

  always #5 clk = ~clk;

  ram_delay_ctrl #(
    .P_NBITS_ADDR(8),
    .P_NBITS_TO  (16),
    .P_N_DEFAULT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_req    (cfg_req),
    .cfg_n      (cfg_n),
    .cfg_timeout(cfg_timeout),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .dl_n       (dl_n),
    .dl_rst     (dl_rst),
    .dl_valid   (dl_valid),
    .busy       (busy),
    .ready      (ready)
  );

  typedef struct {
    int n;
    int tmo;
    int v;        // first edge (counted from the accept edge) at which dl_valid is 1
    int hold;     // cycles cfg_req stays high after the ack
    int exp_rst;  // edge at which dl_rst is seen, 0 = never
    int exp_ack;  // edge at which cfg_ack is seen
    int exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level reference. Edge 0 samples the request. A rejected
  // length is acknowledged one edge later. An accepted one spends one cycle
  // applying and two settling, so dl_rst shows at edge 1 and waiting starts
  // at edge 3; the wait ends at the first later edge that sees dl_valid, or
  // after tmo cycles if that is earlier, and the ack shows one edge after.
  function automatic void model_txn(input int n, input int tmo, input int v,
                                    output int rst_off, output int ack_off, output int err);
    int k;
    if (n < MIN_N) begin
      rst_off = 0;
      ack_off = 1;
      err     = 1;
    end else begin
      k   = (v - 3 > 1) ? v - 3 : 1;
      err = 0;
      if (tmo != 0 && tmo < k) begin
        k   = tmo;
        err = 1;
      end
      rst_off = 1;
      ack_off = 3 + k + 1;
    end
  endfunction

  task automatic wait_idle(input string tag);
    int waited = 0;
    while (busy !== 1'b0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, " reach idle"}, 32'(busy), 0);
    @(posedge clk); #1;
    check({tag, " ready"}, 32'(ready), 1);
  endtask

  task automatic run_txn(input vec_t t, input string tag);
    int first_rst = 0, rst_cnt = 0, first_ack = 0, ack_cnt = 0, err_at = 0;
    cfg_n       = 8'(t.n);
    cfg_timeout = 16'(t.tmo);
    cfg_req     = 1'b1;
    @(posedge clk); #1;   // accept edge
    for (int j = 1; j <= 400; j++) begin
      dl_valid = (j >= t.v);
      if (first_ack != 0 && j > first_ack + t.hold) cfg_req = 1'b0;
      @(posedge clk); #1;
      if (dl_rst === 1'b1) begin
        rst_cnt++;
        if (first_rst == 0) first_rst = j;
      end
      if (cfg_ack === 1'b1) begin
        ack_cnt++;
        if (first_ack == 0) begin
          first_ack = j;
          err_at    = int'(cfg_err);
        end
      end
      if (first_ack != 0 && j >= first_ack + t.hold + 4) break;
    end
    cfg_req  = 1'b0;
    dl_valid = 1'b1;
    if (t.n >= MIN_N) mdl_dl_n = t.n;
    check({tag, " dl_rst edge"}, 32'(first_rst), 32'(t.exp_rst));
    check({tag, " dl_rst count"}, 32'(rst_cnt), (t.exp_rst != 0) ? 1 : 0);
    check({tag, " ack edge"}, 32'(first_ack), 32'(t.exp_ack));
    check({tag, " ack count"}, 32'(ack_cnt), 1);
    check({tag, " err"}, 32'(err_at), 32'(t.exp_err));
    check({tag, " dl_n"}, 32'(dl_n), 32'(mdl_dl_n));
    wait_idle(tag);
  endtask

  // Observe a boot sequence after rst_n is released; dl_valid rises at edge vrise.
  task automatic observe_boot(input int vrise, input string tag);
    int first_rst = 0, rst_cnt = 0, ack_cnt = 0;
    rst_n = 1'b1;
    for (int j = 1; j <= vrise + 20; j++) begin
      dl_valid = (j >= vrise);
      @(posedge clk); #1;
      if (dl_rst === 1'b1) begin
        rst_cnt++;
        if (first_rst == 0) first_rst = j;
      end
      if (cfg_ack === 1'b1) ack_cnt++;
    end
    mdl_dl_n = 16;
    check({tag, " dl_rst edge"}, 32'(first_rst), 2);
    check({tag, " dl_rst count"}, 32'(rst_cnt), 1);
    check({tag, " no ack"}, 32'(ack_cnt), 0);
    check({tag, " dl_n"}, 32'(dl_n), 32'(mdl_dl_n));
    wait_idle(tag);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t rv;
    int   ack_cnt, got_ack;

    // n, tmo, v, hold, exp_rst, exp_ack, exp_err
    vecs[0] = '{37,   0,   80, 1, 1, 81, 0};  // reconfigure, no limit
    vecs[1] = '{ 1,   0,    5, 0, 0,  1, 1};  // reject n=1
    vecs[2] = '{ 0,   7,    5, 2, 0,  1, 1};  // reject n=0
    vecs[3] = '{10,   5, 1000, 0, 1,  9, 1};  // timeout, valid held low
    vecs[4] = '{ 2,   0,    1, 0, 1,  5, 0};  // minimum length, valid already high
    vecs[5] = '{20,   6,    9, 1, 1, 10, 0};  // valid and timeout same cycle
    vecs[6] = '{20,   6,   10, 3, 1, 10, 1};  // timeout one cycle before valid
    vecs[7] = '{255,  1,   50, 0, 1,  5, 1};  // maximum length, shortest timeout

    rst_n = 1'b0; cfg_req = 1'b0; cfg_n = '0; cfg_timeout = '0; dl_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset cfg_ack", 32'(cfg_ack), 0);
    check("reset cfg_err", 32'(cfg_err), 0);
    check("reset dl_rst", 32'(dl_rst), 0);
    check("reset busy", 32'(busy), 1);
    check("reset ready", 32'(ready), 0);
    check("reset dl_n", 32'(dl_n), 16);

    observe_boot(40, "boot");

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Request held 20 cycles past the ack, then dropped for a single edge.
    cfg_n = 8'd12; cfg_timeout = 16'd0; cfg_req = 1'b1;
    @(posedge clk); #1;
    ack_cnt = 0; got_ack = 0;
    for (int j = 1; j <= 200; j++) begin
      dl_valid = (j >= 10);
      @(posedge clk); #1;
      if (cfg_ack === 1'b1) ack_cnt++;
      if (ack_cnt != 0) got_ack++;
      if (got_ack > 20) break;
    end
    mdl_dl_n = 12;
    check("held ack count", 32'(ack_cnt), 1);
    check("held dl_n", 32'(dl_n), 32'(mdl_dl_n));
    cfg_req = 1'b0;
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_n = 8'd3;
    @(posedge clk); #1;   // accept edge
    check("re-req dl_rst early", 32'(dl_rst), 0);
    check("re-req dl_n", 32'(dl_n), 3);
    @(posedge clk); #1;
    check("re-req dl_rst", 32'(dl_rst), 1);
    mdl_dl_n = 3;
    got_ack = 0;
    for (int j = 0; j < 50 && got_ack == 0; j++) begin
      @(posedge clk); #1;
      if (cfg_ack === 1'b1) got_ack = 1;
    end
    check("re-req ack", 32'(got_ack), 1);
    cfg_req = 1'b0;
    wait_idle("re-req");

    for (int i = 0; i < 12; i++) begin
      rv.n    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 255));
      rv.tmo  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
      rv.v    = int'($urandom_range(1, 40));
      rv.hold = int'($urandom_range(0, 3));
      model_txn(rv.n, rv.tmo, rv.v, rv.exp_rst, rv.exp_ack, rv.exp_err);
      run_txn(rv, $sformatf("rnd%0d n=%0d t=%0d v=%0d", i, rv.n, rv.tmo, rv.v));
    end

    // Reset while waiting for dl_valid.
    cfg_n = 8'd50; cfg_timeout = 16'd0; cfg_req = 1'b1;
    @(posedge clk); #1;
    ack_cnt = 0;
    for (int j = 1; j <= 6; j++) begin
      dl_valid = 1'b0;
      @(posedge clk); #1;
      if (cfg_ack === 1'b1) ack_cnt++;
    end
    check("abort dl_n before", 32'(dl_n), 50);
    rst_n = 1'b0; cfg_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      if (cfg_ack === 1'b1) ack_cnt++;
      check("abort busy", 32'(busy), 1);
    end
    check("abort no ack", 32'(ack_cnt), 0);
    check("abort dl_n reset", 32'(dl_n), 16);
    observe_boot(30, "abort boot");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
